// File: rtl/alu_op_sequencer.sv
// Self-timed initiator for the 8-bit ALU port: sweeps the selected function codes in ascending order
// and streams W/c/z results over a valid/ready channel. Optional result statistics: ALU_SEQ_STATS_EN.
//
// state    | meaning
// IDLE     | waiting for a command, cmd_ready high
// SETTLE   | alu_f/alu_a/alu_b driven, counting down the settle time
// RESP     | result held on res_* until the consumer takes it
// FINISH   | one-cycle done pulse, then back to IDLE
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [7:0] cmd_mask,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_f,
  input  logic [7:0] alu_w,
  input  logic       alu_c,
  input  logic       alu_z,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [2:0] res_f,
  output logic [7:0] res_w,
  output logic       res_c,
  output logic       res_z,
  output logic       res_last,
  output logic       busy,
  output logic       done
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [7:0] stat_zero_cnt,
  output logic [7:0] stat_carry_cnt
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  logic [1:0] state;
  logic [7:0] mask_r;
  logic [3:0] cnt;
  logic       accept;
  logic       res_hs;

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    lowest_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_bit = 3'(i);
    end
  endfunction

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FINISH);
  assign accept    = (state == S_IDLE) && cmd_valid;
  assign res_hs    = (state == S_RESP) && res_valid && res_ready;

  // m & (m - 1) drops the lowest set bit, i.e. the code just issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mask_r    <= 8'd0;
      cnt       <= 4'd0;
      alu_a     <= 8'd0;
      alu_b     <= 8'd0;
      alu_f     <= 3'd0;
      res_valid <= 1'b0;
      res_f     <= 3'd0;
      res_w     <= 8'd0;
      res_c     <= 1'b0;
      res_z     <= 1'b0;
      res_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            alu_a <= cmd_a;
            alu_b <= cmd_b;
            if (cmd_mask == 8'd0) begin
              mask_r <= 8'd0;
              state  <= S_FINISH;
            end else begin
              alu_f  <= lowest_bit(cmd_mask);
              mask_r <= cmd_mask & (cmd_mask - 8'd1);
              cnt    <= SETTLE_LOAD;
              state  <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (cnt == 4'd1) begin
            res_w     <= alu_w;
            res_c     <= alu_c;
            res_z     <= alu_z;
            res_f     <= alu_f;
            res_last  <= (mask_r == 8'd0);
            res_valid <= 1'b1;
            cnt       <= 4'd0;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (mask_r == 8'd0) begin
              state <= S_FINISH;
            end else begin
              alu_f  <= lowest_bit(mask_r);
              mask_r <= mask_r & (mask_r - 8'd1);
              cnt    <= SETTLE_LOAD;
              state  <= S_SETTLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_zero_cnt  <= 8'd0;
      stat_carry_cnt <= 8'd0;
    end else if (accept) begin
      stat_zero_cnt  <= 8'd0;
      stat_carry_cnt <= 8'd0;
    end else if (res_hs) begin
      if (res_z && (stat_zero_cnt != 8'hFF))  stat_zero_cnt  <= stat_zero_cnt + 8'd1;
      if (res_c && (stat_carry_cnt != 8'hFF)) stat_carry_cnt <= stat_carry_cnt + 8'd1;
    end
  end
`else
  logic unused_hs;
  assign unused_hs = accept ^ res_hs;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed plus random commands against a queue-based model.
// Build with ALU_SEQ_STATS_EN defined to also check the result statistics.
module tb_alu_op_sequencer;

  localparam int SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a, cmd_b, cmd_mask;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_f;
  logic [7:0] alu_w;
  logic       alu_c, alu_z;
  logic       res_valid, res_ready;
  logic [2:0] res_f;
  logic [7:0] res_w;
  logic       res_c, res_z, res_last;
  logic       busy, done;
`ifdef ALU_SEQ_STATS_EN
  logic [7:0] stat_zero_cnt, stat_carry_cnt;
  int         exp_zc = 0;
  int         exp_cc = 0;
`endif

  int checks = 0;
  int errors = 0;
  bit stub_mode = 1'b0;

  always #5 clk = ~clk;

  // ALU behaviour: returns {c, z, w}; stub mode forces z for F=0,1 and c for F=1
  function automatic logic [9:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] f, input bit stub);
    logic [8:0] s;
    logic [7:0] w;
    logic       c;
    logic       z;
    s = 9'd0;
    w = 8'd0;
    c = 1'b0;
    case (f)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; w = s[7:0]; c = s[8]; end
      3'd1: begin w = a - b; c = (a < b); end
      3'd2: w = a & b;
      3'd3: w = a | b;
      3'd4: w = a ^ b;
      3'd5: begin w = {a[6:0], 1'b0}; c = a[7]; end
      3'd6: begin w = {1'b0, a[7:1]}; c = a[0]; end
      default: w = ~a;
    endcase
    z = (w == 8'd0);
    if (stub) begin
      z = (f <= 3'd1);
      c = (f == 3'd1);
    end
    return {c, z, w};
  endfunction

  assign {alu_c, alu_z, alu_w} = alu_ref(alu_a, alu_b, alu_f, stub_mode);

  alu_op_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_mask(cmd_mask),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_w(alu_w), .alu_c(alu_c), .alu_z(alu_z),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_f(res_f), .res_w(res_w), .res_c(res_c), .res_z(res_z), .res_last(res_last),
    .busy(busy), .done(done)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_zero_cnt(stat_zero_cnt),
    .stat_carry_cnt(stat_carry_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_alu_abf", 32'({alu_a, alu_b, alu_f}), 32'd0);
    chk("rst_res", 32'({res_f, res_w, res_c, res_z, res_last}), 32'd0);
`ifdef ALU_SEQ_STATS_EN
    chk("rst_stats", 32'({stat_zero_cnt, stat_carry_cnt}), 32'd0);
`endif
  endtask

  // Issue one command and follow it to completion; abort_after>=0 resets while that result is pending.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                         input bit rnd, input int hold, input int abort_after);
    logic [2:0] q[$];
    logic [9:0] r;
    int t = 0;
    int rise_t;
    int done_t = 100000;
    int pops = 0;
    int vcnt = 0;
    bit exp_valid;
    bit pend;
    for (int i = 0; i < 8; i++) if (m[i]) q.push_back(3'(i));
    chk("accept_ready", 32'(cmd_ready), 32'd1);
    cmd_a = a;
    cmd_b = b;
    cmd_mask = m;
    cmd_valid = 1'b1;
    rise_t = 1 + SETTLE;
    if (q.size() == 0) done_t = 1;
`ifdef ALU_SEQ_STATS_EN
    exp_zc = 0;
    exp_cc = 0;
`endif
    for (int guard = 0; guard < 400; guard++) begin
      step();
      t++;
      cmd_valid = 1'b0;
      pend = (q.size() > 0);
      exp_valid = pend && (t >= rise_t);
      chk("res_valid", 32'(res_valid), 32'(exp_valid));
      chk("done", 32'(done), 32'(t == done_t));
      chk("busy", 32'(busy), 32'(pend || t <= done_t));
      chk("cmd_ready", 32'(cmd_ready), 32'(!(pend || t <= done_t)));
      chk("alu_ab", 32'({alu_a, alu_b}), 32'({a, b}));
      if (pend) chk("alu_f", 32'(alu_f), 32'(q[0]));
      if (exp_valid) begin
        r = alu_ref(a, b, q[0], stub_mode);
        chk("res_f", 32'(res_f), 32'(q[0]));
        chk("res_wcz", 32'({res_w, res_c, res_z}), 32'({r[7:0], r[9], r[8]}));
        chk("res_last", 32'(res_last), 32'(q.size() == 1));
      end
`ifdef ALU_SEQ_STATS_EN
      chk("stat_zero", 32'(stat_zero_cnt), 32'(exp_zc));
      chk("stat_carry", 32'(stat_carry_cnt), 32'(exp_cc));
`endif
      if (t == done_t + 1) return;
      if (exp_valid && pops == abort_after) begin
        rst_n = 1'b0;
        #1;
        check_reset_state();
        step();
        check_reset_state();
        res_ready = 1'b0;
        rst_n = 1'b1;
`ifdef ALU_SEQ_STATS_EN
        exp_zc = 0;
        exp_cc = 0;
`endif
        return;
      end
      res_ready = rnd ? ($urandom_range(0, 3) != 0) : (vcnt >= hold);
      if ((pend || t <= done_t) &&
          ($urandom_range(0, 4) == 0 || (hold > 0 && exp_valid && vcnt == 2))) begin
        cmd_valid = 1'b1;
        cmd_a = 8'($urandom);
        cmd_b = 8'($urandom);
        cmd_mask = 8'($urandom);
      end
      if (exp_valid) begin
        if (res_ready) begin
`ifdef ALU_SEQ_STATS_EN
          if (r[8] && exp_zc < 255) exp_zc++;
          if (r[9] && exp_cc < 255) exp_cc++;
`endif
          void'(q.pop_front());
          pops++;
          vcnt = 0;
          if (q.size() == 0) done_t = t + 1;
          else rise_t = t + 1 + SETTLE;
        end else begin
          vcnt++;
        end
      end
    end
    chk("cmd_timeout", 32'(t), 32'(done_t + 1));
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_a = 8'd0;
    cmd_b = 8'd0;
    cmd_mask = 8'd0;
    res_ready = 1'b0;
    #1;
    check_reset_state();
    step();
    step();
    check_reset_state();
    rst_n = 1'b1;
    step();
    check_reset_state();

    run_cmd(8'h26, 8'h03, 8'hFF, 1'b0, 0, -1);
    run_cmd(8'h5A, 8'hC3, 8'h00, 1'b0, 0, -1);
    run_cmd(8'h80, 8'h90, 8'h81, 1'b1, 0, -1);
    run_cmd(8'h0F, 8'h01, 8'h04, 1'b0, 5, -1);
    run_cmd(8'h11, 8'h22, 8'hFF, 1'b1, 0, 2);
    run_cmd(8'h33, 8'h44, 8'h06, 1'b1, 0, -1);

`ifdef ALU_SEQ_STATS_EN
    stub_mode = 1'b1;
    run_cmd(8'h01, 8'h02, 8'hFF, 1'b0, 0, -1);
    chk("stat_zero_final", 32'(stat_zero_cnt), 32'd2);
    chk("stat_carry_final", 32'(stat_carry_cnt), 32'd1);
    stub_mode = 1'b0;
    run_cmd(8'hA5, 8'h5A, 8'h10, 1'b0, 0, -1);
`endif

    for (int n = 0; n < 25; n++) begin
      run_cmd(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
